// File: rtl/serial_adder_8bit_if.sv
// Controller-to-adder bundle: operand request from the calculator FSM and the
// registered result/status returned by the bit-serial adder.
interface serial_adder_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CarryIn;
  logic [WIDTH-1:0] Sum;
  logic             error;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, CarryIn,
    input  Sum, error, busy, done
  );

  modport slave (
    input  start, A, B, CarryIn,
    output Sum, error, busy, done
  );
endinterface

// File: rtl/serial_adder_8bit.sv
// Bit-serial unsigned adder: one full-adder step per clock, LSB first, giving
// {error,Sum} = A + B + CarryIn with a one-cycle done pulse on completion.
module serial_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_8bit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bitSum;
  logic             bitCarry;
  logic             lastBit;

  assign bitSum   = aShift_q[0] ^ bShift_q[0] ^ carry_q;
  assign bitCarry = (aShift_q[0] & bShift_q[0]) |
                    (aShift_q[0] & carry_q)     |
                    (bShift_q[0] & carry_q);
  assign lastBit  = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aShift_q <= '0;
      bShift_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      sum_q    <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // busy/done are computed for the next state so they leave the flops aligned with it.
  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    result_d = result_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_d    = sum_q;
    error_d  = error_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          aShift_d = bus.A;
          bShift_d = bus.B;
          carry_d  = bus.CarryIn;
          result_d = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = ADD;
        end
      end

      ADD: begin
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        result_d = {bitSum, result_q[WIDTH-1:1]};
        carry_d  = bitCarry;
        count_d  = count_q + CW'(1);
        busy_d   = 1'b1;
        if (lastBit) begin
          sum_d   = {bitSum, result_q[WIDTH-1:1]};
          error_d = bitCarry;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Sum   = sum_q;
  assign bus.error = error_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Self-checking bench for serial_adder_8bit: vector table, random operands and
// hand-written corner sequences, with results matched through a scoreboard queue.
module tb_serial_adder_8bit;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expErr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         testsRun = 0;
  int         testsFailed = 0;
  logic [8:0] expQ[$];
  vec_t       vecs[8];
  logic [7:0] bbA[4];
  logic [7:0] bbB[4];
  logic       bbC[4];

  serial_adder_8bit_if #(.WIDTH(WIDTH)) bus();

  serial_adder_8bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every done pulse consumes the oldest expected result; a pulse with nothing queued is an error.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && bus.done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected done", 32'(bus.done), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("Sum", 32'(bus.Sum), 32'(e[7:0]));
        checkOutput("error", 32'(bus.error), 32'(e[8]));
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) checkOutput("idle timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) checkOutput("done timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input logic [7:0] expSum, input logic expErr);
    int n;
    waitIdle();
    bus.A       = a;
    bus.B       = b;
    bus.CarryIn = cin;
    bus.start   = 1'b1;
    expQ.push_back({expErr, expSum});
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy after accept", 32'(bus.busy), 32'd1);
    waitDone(n);
    checkOutput("latency", 32'(n), 32'(WIDTH));
    checkOutput("busy in DONE", 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput("done width", 32'(bus.done), 32'd0);
    checkOutput("busy after DONE", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int prevAcc;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] full;

    vecs[0] = '{8'h0F, 8'h05, 1'b0, 8'h14, 1'b0};
    vecs[1] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    bbA[0] = 8'h12; bbB[0] = 8'h34; bbC[0] = 1'b0;
    bbA[1] = 8'hC8; bbB[1] = 8'h64; bbC[1] = 1'b1;
    bbA[2] = 8'h01; bbB[2] = 8'hFE; bbC[2] = 1'b1;
    bbA[3] = 8'h55; bbB[3] = 8'h22; bbC[3] = 1'b0;

    bus.start   = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    bus.CarryIn = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset Sum", 32'(bus.Sum), 32'd0);
    checkOutput("reset error", 32'(bus.error), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].expSum, vecs[i].expErr);

    for (int i = 0; i < 10; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      applyStimulus(ra, rb, rc, full[7:0], full[8]);
    end

    // A second start (with new operands) while busy must not disturb the running add.
    waitIdle();
    bus.A = 8'h81; bus.B = 8'h81; bus.CarryIn = 1'b0; bus.start = 1'b1;
    expQ.push_back({1'b1, 8'h02});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.A = 8'h01; bus.B = 8'h01; bus.CarryIn = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(n);
    checkOutput("ignored-start latency", 32'(n), 32'(WIDTH - 4));
    repeat (WIDTH + 4) @(negedge clk);
    checkOutput("ignored-start busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of an operation aborts it with no done pulse.
    waitIdle();
    bus.A = 8'hFF; bus.B = 8'h01; bus.CarryIn = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort Sum", 32'(bus.Sum), 32'd0);
    checkOutput("abort error", 32'(bus.error), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    repeat (WIDTH + 2) @(negedge clk);
    checkOutput("abort stays idle", 32'(bus.busy), 32'd0);
    applyStimulus(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

    // start held high: accepts must be spaced WIDTH+2 cycles apart.
    waitIdle();
    prevAcc = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (bus.busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (bus.busy) checkOutput("b2b idle timeout", 32'(bus.busy), 32'd0);
      bus.A = bbA[i]; bus.B = bbB[i]; bus.CarryIn = bbC[i]; bus.start = 1'b1;
      full = {1'b0, bbA[i]} + {1'b0, bbB[i]} + {8'd0, bbC[i]};
      expQ.push_back(full);
      if (i > 0) checkOutput("accept spacing", 32'(cyc - prevAcc), 32'(WIDTH + 2));
      prevAcc = cyc;
      @(negedge clk);
      if (i == 3) bus.start = 1'b0;
    end
    waitDone(n);
    repeat (WIDTH + 4) @(negedge clk);

    checkOutput("pending results", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
